// File: rtl/eoc_column_readout_if.sv
// ----------------------------------------------------------------------------
// eoc_column_readout_if
//
// Purpose: bundles the two handshake buses of the end-of-column readout.
//   Column side : 4-phase request/acknowledge from the last super pixel.
//   Output side : valid/ready stream of 32-bit readout frames.
//
// Signals:
//   col_data  [DW-1:0]  word from the column chain, valid while col_req high
//   col_req             column request
//   col_ack             acknowledge back to the column chain
//   out_data  [31:0]    frame {col_addr, word, parity}
//   out_valid           out_data holds a frame
//   out_ready           downstream accepts the frame this cycle
//
// Modports:
//   master : the environment (drives requests and out_ready)
//   slave  : the readout block
// ----------------------------------------------------------------------------
interface eoc_column_readout_if #(
   parameter int DW = 26
);
   logic [DW-1:0] col_data;
   logic          col_req;
   logic          col_ack;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output col_data,
      output col_req,
      input  col_ack,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  col_data,
      input  col_req,
      output col_ack,
      output out_data,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/eoc_column_readout.sv
// ----------------------------------------------------------------------------
// eoc_column_readout
//
// Purpose: end-of-column readout. Accepts arbiter words from the column chain
// over a 4-phase handshake, drops all-zero words (counting them), buffers the
// rest in a DEPTH-word FIFO and streams them out as 32-bit frames
// {col_addr, word, even-parity bit} through a registered valid/ready output.
//
// Ports:
//   clk_40MHz   sole clock, rising edge
//   rst         synchronous, active-high reset
//   bus         eoc_column_readout_if.slave (column + output handshakes)
//   col_addr    static column address, sampled when a word leaves the FIFO
//   fifo_level  words held in the FIFO (output register not included)
//   null_cnt    dropped all-zero words, saturating at 255
// ----------------------------------------------------------------------------
module eoc_column_readout #(
   parameter int DW    = 26,
   parameter int DEPTH = 8
) (
   input  logic                 clk_40MHz,
   input  logic                 rst,
   eoc_column_readout_if.slave  bus,
   input  logic [4:0]           col_addr,
   output logic [3:0]           fifo_level,
   output logic [7:0]           null_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Helper functions
   // -------------------------------------------------------------------------
   // Bit 0 makes the XOR over the whole frame zero.
   function automatic logic [31:0] make_frame(input logic [4:0]    addr,
                                              input logic [DW-1:0] word);
      logic [30:0] body;
      body = {addr, word};
      return {body, ^body};
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [DW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW-1:0]  rptr_q, rptr_d;
   logic [3:0]     level_q, level_d;
   logic [7:0]     null_q, null_d;
   logic           ov_q, ov_d;
   logic [31:0]    od_q, od_d;

   logic           full;
   logic           empty;
   logic           capture;
   logic           wr_en;
   logic           null_hit;
   logic           rd_en;

   assign full  = (level_q == 4'(DEPTH));
   assign empty = (level_q == 4'd0);

   // -------------------------------------------------------------------------
   // Column handshake FSM
   // A word is captured only on the IDLE->ACK edge; while the FIFO is full
   // the request is simply left waiting, which is the column backpressure.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.col_req && !full) begin
               capture = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!bus.col_req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.col_ack = (state_q == ACK);

   // -------------------------------------------------------------------------
   // FIFO write / null filtering
   // -------------------------------------------------------------------------
   always_comb begin
      wr_en    = capture && (bus.col_data != '0);
      null_hit = capture && (bus.col_data == '0);
      wptr_d   = wr_en ? wptr_q + AW'(1) : wptr_q;
      null_d   = null_hit ? sat_inc8(null_q) : null_q;
   end

   // -------------------------------------------------------------------------
   // FIFO read into the output register
   // The register is only loaded while downstream is ready, so with out_ready
   // low every buffered word stays in the FIFO and fifo_level can reach DEPTH.
   // When a frame is consumed and the FIFO has more, the register reloads on
   // the same edge, giving one frame per cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      rd_en  = !empty && bus.out_ready;
      rptr_d = rd_en ? rptr_q + AW'(1) : rptr_q;
      ov_d   = ov_q;
      od_d   = od_q;
      if (rd_en) begin
         ov_d = 1'b1;
         od_d = make_frame(col_addr, mem_q[rptr_q]);
      end else if (ov_q && bus.out_ready) begin
         ov_d = 1'b0;
      end
   end

   // Full check above uses the level before this edge, so a read in the
   // capture cycle never frees a slot for that same capture.
   always_comb begin
      level_d = level_q + {3'b000, wr_en} - {3'b000, rd_en};
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_40MHz) begin
      if (rst) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         null_q  <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         null_q  <= null_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge clk_40MHz) begin
      if (wr_en) begin
         mem_q[wptr_q] <= bus.col_data;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign fifo_level    = level_q;
   assign null_cnt      = null_q;

endmodule

// File: tb/tb_eoc_column_readout.sv
module tb_eoc_column_readout;
   localparam int DW    = 26;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] col_addr;
   logic [3:0] fifo_level;
   logic [7:0] null_cnt;

   always #12 clk = ~clk;

   eoc_column_readout_if #(.DW(DW)) bus ();

   eoc_column_readout #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk_40MHz  (clk),
      .rst        (rst),
      .bus        (bus),
      .col_addr   (col_addr),
      .fifo_level (fifo_level),
      .null_cnt   (null_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int rdy_mode = 0;  // 0: held by main, 1: random, 2: toggle

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] frame_f(input logic [4:0] a, input logic [DW-1:0] w);
      logic [30:0] b;
      b = {a, w};
      return {b, ^b};
   endfunction

   // ---------------- behavioural model ----------------
   bit            model_on = 1'b0;
   bit            ack_m;
   logic [DW-1:0] q_m [$];
   bit            ov_m;
   logic [31:0]   od_m;
   int            nc_m;
   bit            m_cap, m_pop, m_cons;
   logic [DW-1:0] m_w;

   always @(posedge clk) begin
      if (rst) begin
         model_on = 1'b1;
         ack_m = 1'b0;
         q_m.delete();
         ov_m = 1'b0;
         od_m = '0;
         nc_m = 0;
      end else if (model_on) begin
         m_cap  = !ack_m && bus.col_req && (q_m.size() < DEPTH);
         m_pop  = (q_m.size() > 0) && bus.out_ready;
         m_cons = ov_m && bus.out_ready;
         if (m_pop) begin
            m_w  = q_m.pop_front();
            od_m = frame_f(col_addr, m_w);
            ov_m = 1'b1;
         end else if (m_cons) begin
            ov_m = 1'b0;
         end
         if (m_cap) begin
            if (bus.col_data == '0) begin
               if (nc_m < 255) nc_m++;
            end else begin
               q_m.push_back(bus.col_data);
            end
            ack_m = 1'b1;
         end else if (ack_m && !bus.col_req) begin
            ack_m = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("col_ack", {31'b0, bus.col_ack}, {31'b0, ack_m});
         check("out_valid", {31'b0, bus.out_valid}, {31'b0, ov_m});
         check("fifo_level", {28'b0, fifo_level}, q_m.size());
         check("null_cnt", {24'b0, null_cnt}, nc_m);
         if (ov_m) check("out_data", bus.out_data, od_m);
         if (bus.out_valid === 1'b1) check("parity", {31'b0, ^bus.out_data}, 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) bus.out_ready = ~bus.out_ready;
   endtask

   task automatic wait_ack(input logic lvl, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (bus.col_ack === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      bit ok;
      bus.col_data = w;
      bus.col_req  = 1'b1;
      wait_ack(1'b1, 300, ok);
      check("push_ack_timeout", {31'b0, ok}, 32'd1);
      bus.col_req = 1'b0;
      wait_ack(1'b0, 10, ok);
      check("push_release_timeout", {31'b0, ok}, 32'd1);
   endtask

   logic [DW-1:0] words [4];
   logic [31:0]   held;
   bit            ok;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      col_addr = 5'd3;
      bus.col_req = 1'b0;
      bus.col_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("rst_col_ack", {31'b0, bus.col_ack}, 32'd0);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_fifo_level", {28'b0, fifo_level}, 32'd0);
      check("rst_null_cnt", {24'b0, null_cnt}, 32'd0);
      rst = 1'b0;
      tick();

      // Single word, literal frame and latency
      bus.col_data = 26'h2A55F3;
      bus.col_req  = 1'b1;
      tick();
      check("t1_ack", {31'b0, bus.col_ack}, 32'd1);
      check("t1_level", {28'b0, fifo_level}, 32'd1);
      check("t1_valid_early", {31'b0, bus.out_valid}, 32'd0);
      tick();
      check("t1_valid", {31'b0, bus.out_valid}, 32'd1);
      check("t1_frame", bus.out_data, 32'h1854ABE7);
      bus.col_req = 1'b0;
      tick();
      check("t1_ack_drop", {31'b0, bus.col_ack}, 32'd0);
      tick();

      // Null words
      repeat (3) push('0);
      tick();
      check("t2_null_cnt", {24'b0, null_cnt}, 32'd3);
      check("t2_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t2_level", {28'b0, fifo_level}, 32'd0);

      // Fill to full, ninth held
      bus.out_ready = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) push(26'h0100000 + 26'(i * 7 + 1));
      check("t3_level_full", {28'b0, fifo_level}, 32'd8);
      bus.col_data = 26'h3ABCDEF;
      bus.col_req  = 1'b1;
      repeat (4) begin
         tick();
         check("t3_held_ack", {31'b0, bus.col_ack}, 32'd0);
      end
      bus.out_ready = 1'b1;
      wait_ack(1'b1, 20, ok);
      check("t3_ninth_ack", {31'b0, ok}, 32'd1);
      bus.col_req = 1'b0;
      repeat (15) tick();
      check("t3_drained", {28'b0, fifo_level}, 32'd0);

      // Stall for 10 cycles, then drain one per cycle
      bus.out_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         words[i] = 26'h2000000 | 26'($urandom_range(1, 1000000));
         push(words[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("t4_first", bus.out_data, frame_f(col_addr, words[0]));
      held = bus.out_data;
      repeat (10) begin
         tick();
         check("t4_stable", bus.out_data, held);
         check("t4_stall_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         tick();
         check("t4_drain", bus.out_data, frame_f(col_addr, words[k]));
      end
      tick();
      check("t4_empty", {31'b0, bus.out_valid}, 32'd0);

      // Wrap with toggling ready
      rdy_mode = 2;
      for (int i = 0; i < 20; i++) push(26'($urandom_range(1, (1 << 26) - 1)));
      repeat (30) tick();
      rdy_mode = 0;
      bus.out_ready = 1'b0;
      tick();

      // Reset mid-operation
      for (int i = 0; i < 5; i++) push(26'h0F0F0F0 + 26'(i));
      bus.col_data = 26'h1234567;
      bus.col_req  = 1'b1;
      wait_ack(1'b1, 10, ok);
      check("t6_ack", {31'b0, ok}, 32'd1);
      rst = 1'b1;
      tick();
      check("t6_rst_ack", {31'b0, bus.col_ack}, 32'd0);
      check("t6_rst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t6_rst_level", {28'b0, fifo_level}, 32'd0);
      check("t6_rst_null", {24'b0, null_cnt}, 32'd0);
      rst = 1'b0;
      tick();
      check("t6_recapture", {31'b0, bus.col_ack}, 32'd1);
      bus.col_req = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("t6_fresh_valid", {31'b0, bus.out_valid}, 32'd1);
      check("t6_fresh_frame", bus.out_data, frame_f(col_addr, 26'h1234567));
      tick();
      check("t6_no_stale", {31'b0, bus.out_valid}, 32'd0);

      // Random traffic
      rdy_mode = 1;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) col_addr = 5'($urandom);
         if ($urandom_range(0, 5) == 0) push('0);
         else push(26'($urandom_range(1, (1 << 26) - 1)));
         repeat ($urandom_range(0, 3)) tick();
      end
      rdy_mode = 0;
      bus.out_ready = 1'b1;
      repeat (15) tick();

      // Null counter saturation
      repeat (260) push('0);
      tick();
      check("t8_null_sat", {24'b0, null_cnt}, 32'd255);
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
